// File: rtl/xillylite_gpio_pkg.sv
// Register map constants and sizing helpers shared by the Xillybus Lite GPIO bank.
package xillylite_gpio_pkg;

  localparam int unsigned OFS_IN      = 32'h00;
  localparam int unsigned OFS_OUT     = 32'h04;
  localparam int unsigned OFS_DIR     = 32'h08;
  localparam int unsigned OFS_RISE_EN = 32'h0C;
  localparam int unsigned OFS_FALL_EN = 32'h10;
  localparam int unsigned OFS_STATUS  = 32'h14;
  localparam int unsigned OFS_SET     = 32'h18;
  localparam int unsigned OFS_CLR     = 32'h1C;
  localparam int unsigned BANK_STRIDE = 32'h20;
  localparam int unsigned OFS_CTRL    = 32'h100;
  localparam int unsigned OFS_INFO    = 32'h104;

  // Word index of each register inside a bank.
  typedef enum logic [2:0] {
    REG_IN      = 3'(OFS_IN / 4),
    REG_OUT     = 3'(OFS_OUT / 4),
    REG_DIR     = 3'(OFS_DIR / 4),
    REG_RISE_EN = 3'(OFS_RISE_EN / 4),
    REG_FALL_EN = 3'(OFS_FALL_EN / 4),
    REG_STATUS  = 3'(OFS_STATUS / 4),
    REG_SET     = 3'(OFS_SET / 4),
    REG_CLR     = 3'(OFS_CLR / 4)
  } bank_reg_e;

  function automatic int unsigned num_banks(input int unsigned pins);
    return (pins + 31) / 32;
  endfunction

endpackage

// File: rtl/xillylite_gpio_bank_sync_edge.sv
// Multi-stage input synchroniser with a previous-sample flop for edge detection.
module gpio_sync_edge #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [WIDTH-1:0]             prev_q, prev_d;

  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
    prev_d = stage_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign sync = stage_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/xillylite_gpio_bank.sv
// N-pin GPIO controller on the Xillybus Lite user port: direction, set/clear,
// synchronised inputs and W1C edge interrupts.
module xillylite_gpio_bank
  import xillylite_gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS    = 54,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic                  user_wren,
  input  logic [3:0]            user_wstrb,
  input  logic                  user_rden,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [31:0]           user_wr_data,
  output logic [31:0]           user_rd_data,
  output logic                  user_irq,
  input  logic [NUM_PINS-1:0]   gpio_i,
  output logic [NUM_PINS-1:0]   gpio_o,
  output logic [NUM_PINS-1:0]   gpio_t
);

  localparam int unsigned NB        = num_banks(NUM_PINS);
  localparam logic [2:0]  PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [NUM_PINS-1:0] out_q, out_d, dir_q, dir_d;
  logic [NUM_PINS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NUM_PINS-1:0] status_q, status_d;
  logic                ctrl_q, ctrl_d, irq_q, irq_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [2:0]          prime_q, prime_d;

  logic [NUM_PINS-1:0] sync_v, rise_v, fall_v, edge_set;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic                bank_hit, ctrl_hit, info_hit, primed, unused_addr;
  logic [1:0]          bank_sel;
  bank_reg_e           reg_sel;
  logic [31:0]         bmask, rdata;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    localparam int unsigned LO = b * 32;
    localparam int unsigned W  = (NUM_PINS - LO > 32) ? 32 : NUM_PINS - LO;
    gpio_sync_edge #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (user_clk),
      .rst_n (user_rst_n),
      .din   (gpio_i[LO +: W]),
      .sync  (sync_v[LO +: W]),
      .rise  (rise_v[LO +: W]),
      .fall  (fall_v[LO +: W])
    );
  end

  assign addr_w      = {user_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr = ^user_addr[1:0];
  assign bank_hit    = addr_w < ADDR_WIDTH'(NB * BANK_STRIDE);
  assign ctrl_hit    = addr_w == ADDR_WIDTH'(OFS_CTRL);
  assign info_hit    = addr_w == ADDR_WIDTH'(OFS_INFO);
  assign bank_sel    = addr_w[6:5];
  assign reg_sel     = bank_reg_e'(addr_w[4:2]);
  assign bmask       = {{8{user_wstrb[3]}}, {8{user_wstrb[2]}}, {8{user_wstrb[1]}}, {8{user_wstrb[0]}}};

  // Edges stay masked until the synchroniser has flushed its reset value.
  assign primed   = prime_q == PRIME_MAX;
  assign edge_set = primed ? ((rise_v & rise_en_q) | (fall_v & fall_en_q)) : '0;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    ctrl_d    = ctrl_q;
    if (user_wren && bank_hit) begin
      for (int unsigned p = 0; p < NUM_PINS; p++) begin
        if (bank_sel == 2'(p >> 5) && bmask[5'(p)]) begin
          case (reg_sel)
            REG_OUT:     out_d[p]     = user_wr_data[5'(p)];
            REG_DIR:     dir_d[p]     = user_wr_data[5'(p)];
            REG_RISE_EN: rise_en_d[p] = user_wr_data[5'(p)];
            REG_FALL_EN: fall_en_d[p] = user_wr_data[5'(p)];
            REG_STATUS:  if (user_wr_data[5'(p)]) status_d[p] = 1'b0;
            REG_SET:     if (user_wr_data[5'(p)]) out_d[p] = 1'b1;
            REG_CLR:     if (user_wr_data[5'(p)]) out_d[p] = 1'b0;
            default:     ;
          endcase
        end
      end
    end
    // Applied after the W1C so a same-cycle edge keeps the bit set.
    status_d = status_d | edge_set;
    if (user_wren && ctrl_hit && user_wstrb[0]) ctrl_d = user_wr_data[0];
    irq_d   = ctrl_q & (|status_q);
    prime_d = primed ? prime_q : prime_q + 3'd1;
  end

  always_comb begin
    rdata = '0;
    if (bank_hit) begin
      for (int unsigned p = 0; p < NUM_PINS; p++) begin
        if (bank_sel == 2'(p >> 5)) begin
          case (reg_sel)
            REG_IN:      rdata[5'(p)] = sync_v[p];
            REG_OUT:     rdata[5'(p)] = out_q[p];
            REG_DIR:     rdata[5'(p)] = dir_q[p];
            REG_RISE_EN: rdata[5'(p)] = rise_en_q[p];
            REG_FALL_EN: rdata[5'(p)] = fall_en_q[p];
            REG_STATUS:  rdata[5'(p)] = status_q[p];
            default:     ;
          endcase
        end
      end
    end else if (ctrl_hit) begin
      rdata = {31'd0, ctrl_q};
    end else if (info_hit) begin
      rdata = {8'd0, 8'(SYNC_STAGES), 8'(NB), 8'(NUM_PINS)};
    end
    rd_data_d = user_rden ? rdata : rd_data_q;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      ctrl_q    <= 1'b0;
      irq_q     <= 1'b0;
      rd_data_q <= '0;
      prime_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      ctrl_q    <= ctrl_d;
      irq_q     <= irq_d;
      rd_data_q <= rd_data_d;
      prime_q   <= prime_d;
    end
  end

  assign gpio_o       = out_q;
  assign gpio_t       = ~dir_q;
  assign user_irq     = irq_q;
  assign user_rd_data = rd_data_q;

endmodule
